// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: shared constants, state encoding and selector-width helper for the round-robin mux
package mux_rr_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR = 1'b1;
  localparam int CNT_W = 16;
  typedef enum logic {ST_EMPTY, ST_FULL} ost_e;
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_rr_nto1_pick.sv
// rr_pick: rotating-priority search for the first requester after ptr, wrapping mod N_CH
module rr_pick
  import mux_rr_pkg::*;
#(
  parameter int N_CH = 8,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  // walk from the farthest candidate back to ptr+1 so the nearest requester wins last
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = SEL_W'((int'(ptr) + k) % N_CH);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end
endmodule

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: registered N-to-1 valid/ready mux, manual or round-robin; MUX_RR_STATS_EN adds per-channel grant counters
module mux_rr_nto1
  import mux_rr_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int WIDTH = 3,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MUX_RR_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0] grant_cnt
`endif
);
  ost_e state, state_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_idx, gnt;
  logic rr_vld, man_vld, gnt_vld, load, xfer;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req(in_valid),
    .ptr(rr_ptr),
    .gnt_idx(rr_idx),
    .gnt_vld(rr_vld)
  );

  // grant selection and one-hot ready back to the winning producer
  always_comb begin
    man_vld = (int'(sel) < N_CH) && in_valid[sel];
    gnt_vld = (mode == MODE_RR) ? rr_vld : man_vld;
    gnt = (mode == MODE_RR) ? rr_idx : sel;
    load = (state == ST_EMPTY) || out_ready;
    xfer = load && gnt_vld;
    in_ready = '0;
    in_ready[gnt] = xfer;
  end

  // output FSM: refill on every load, drain to EMPTY when nothing is granted
  always_comb begin
    state_nxt = state;
    if (load) state_nxt = gnt_vld ? ST_FULL : ST_EMPTY;
  end

  assign out_valid = (state == ST_FULL);

  // state, output word and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      out_data <= '0;
      out_sel <= '0;
      rr_ptr <= SEL_W'(N_CH - 1);
    end else begin
      state <= state_nxt;
      if (xfer) begin
        out_data <= in_data[gnt*WIDTH +: WIDTH];
        out_sel <= gnt;
        if (mode == MODE_RR) rr_ptr <= gnt;
      end
    end
  end

`ifdef MUX_RR_STATS_EN
  logic [CNT_W-1:0] cnt [N_CH];

  // saturating per-channel transfer counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (xfer && cnt[gnt] != '1) begin
      cnt[gnt] <= cnt[gnt] + 1'b1;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_cnt
    assign grant_cnt[c*CNT_W +: CNT_W] = cnt[c];
  end
`endif
endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb_mux_rr_nto1: directed and randomized checks of mux_rr_nto1 against a cycle-level reference model
module tb_mux_rr_nto1;
  localparam int N = 8;
  localparam int W = 3;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid, in_ready;
  logic mode;
  logic [SW-1:0] sel;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_sel;
  logic out_valid, out_ready;
`ifdef MUX_RR_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  mux_rr_nto1 #(.N_CH(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .sel(sel),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_RR_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  bit m_valid;
  int m_data, m_sel, m_ptr;
  int m_cnt [N];
  bit e_load, e_ok;
  int e_g;
  logic [N-1:0] e_rdy;

  task automatic model_reset();
    m_valid = 0;
    m_data = 0;
    m_sel = 0;
    m_ptr = N - 1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic predict();
    e_load = !m_valid || out_ready;
    e_ok = 0;
    e_g = 0;
    if (mode == 1'b0) begin
      if (in_valid[sel]) begin
        e_ok = 1;
        e_g = int'(sel);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!e_ok && in_valid[c]) begin
          e_ok = 1;
          e_g = c;
        end
      end
    end
    e_rdy = '0;
    if (e_load && e_ok) e_rdy[e_g] = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
    predict();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (e_load) begin
      if (e_ok) begin
        m_valid = 1;
        m_data = int'(in_data[e_g*W +: W]);
        m_sel = e_g;
        if (mode) m_ptr = e_g;
        if (m_cnt[e_g] < 65535) m_cnt[e_g]++;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic ident_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i);
  endtask

  task automatic test_reset();
    in_valid = '0;
    mode = 1'b0;
    sel = '0;
    out_ready = 1'b0;
    ident_data();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_chk++;
    if (out_data !== '0 || out_sel !== '0) begin n_fail++; $display("FAIL reset_regs got data=%0d sel=%0d want 0/0", out_data, out_sel); end
    n_chk++;
    if (in_ready !== '0) begin n_fail++; $display("FAIL reset_ready got %b want 0", in_ready); end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_manual_sweep();
    logic [N-1:0] oh;
    mode = 1'b0;
    in_valid = '1;
    out_ready = 1'b1;
    for (int s = 7; s >= 0; s--) begin
      sel = SW'(s);
      oh = '0;
      oh[s] = 1'b1;
      settle();
      n_chk++;
      if (in_ready !== oh) begin n_fail++; $display("FAIL manual_ready sel=%0d got %b want %b", s, in_ready, oh); end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== W'(s) || out_sel !== SW'(s)) begin
        n_fail++;
        $display("FAIL manual_out sel=%0d got v=%b d=%0d s=%0d want 1/%0d/%0d", s, out_valid, out_data, out_sel, s, s);
      end
    end
  endtask

  task automatic test_rr_fair();
    apply_reset();
    mode = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      settle();
      n_chk++;
      if (in_ready !== e_rdy) begin n_fail++; $display("FAIL rr_ready k=%0d got %b want %b", k, in_ready, e_rdy); end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== SW'(k % N) || out_data !== W'(k % N)) begin
        n_fail++;
        $display("FAIL rr_seq k=%0d got v=%b s=%0d d=%0d want 1/%0d/%0d", k, out_valid, out_sel, out_data, k % N, k % N);
      end
    end
`ifdef MUX_RR_STATS_EN
    for (int c = 0; c < N; c++) begin
      n_chk++;
      if (grant_cnt[c*16 +: 16] !== 16'd2) begin n_fail++; $display("FAIL stats_rr ch=%0d got %0d want 2", c, grant_cnt[c*16 +: 16]); end
    end
`endif
  endtask

  task automatic test_sparse_rr();
    int exp_seq [4] = '{2, 6, 2, 6};
    apply_reset();
    mode = 1'b1;
    in_valid = 8'b0100_0100;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== SW'(exp_seq[k])) begin
        n_fail++;
        $display("FAIL sparse_seq k=%0d got v=%b s=%0d want 1/%0d", k, out_valid, out_sel, exp_seq[k]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] hd;
    logic [SW-1:0] hs;
    hd = out_data;
    hs = out_sel;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_chk++;
      if (in_ready !== '0) begin n_fail++; $display("FAIL bp_ready k=%0d got %b want 0", k, in_ready); end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== hd || out_sel !== hs) begin
        n_fail++;
        $display("FAIL bp_hold k=%0d got v=%b d=%0d s=%0d want 1/%0d/%0d", k, out_valid, out_data, out_sel, hd, hs);
      end
    end
    out_ready = 1'b1;
    settle();
    n_chk++;
    if (in_ready !== 8'b0000_0100) begin n_fail++; $display("FAIL bp_release_ready got %b want 00000100", in_ready); end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_sel !== 3'd2) begin n_fail++; $display("FAIL bp_release got v=%b s=%0d want 1/2", out_valid, out_sel); end
  endtask

  task automatic test_no_grant();
    mode = 1'b0;
    sel = 3'd7;
    in_valid = 8'h7F;
    out_ready = 1'b0;
    settle();
    n_chk++;
    if (in_ready !== '0) begin n_fail++; $display("FAIL nogrant_ready_full got %b want 0", in_ready); end
    tick();
    out_ready = 1'b1;
    settle();
    n_chk++;
    if (in_ready !== '0) begin n_fail++; $display("FAIL nogrant_ready got %b want 0", in_ready); end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || out_sel !== 3'd2) begin n_fail++; $display("FAIL nogrant_drop got v=%b s=%0d want 0/2", out_valid, out_sel); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", out_valid); end
    model_reset();
    rst_n = 1'b1;
    settle();
    n_chk++;
    if (in_ready !== 8'b0000_0001) begin n_fail++; $display("FAIL midreset_ready got %b want 00000001", in_ready); end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_sel !== 3'd0) begin n_fail++; $display("FAIL midreset_restart got v=%b s=%0d want 1/0", out_valid, out_sel); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      in_data = N*W'($urandom);
      in_valid = N'($urandom);
      mode = 1'($urandom_range(0, 1));
      sel = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      n_chk++;
      if (in_ready !== e_rdy) begin n_fail++; $display("FAIL rand_ready k=%0d got %b want %b", k, in_ready, e_rdy); end
      tick();
      n_chk++;
      if (out_valid !== m_valid || out_data !== W'(m_data) || out_sel !== SW'(m_sel)) begin
        n_fail++;
        $display("FAIL rand_out k=%0d got v=%b d=%0d s=%0d want %b/%0d/%0d", k, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
`ifdef MUX_RR_STATS_EN
    for (int c = 0; c < N; c++) begin
      n_chk++;
      if (grant_cnt[c*16 +: 16] !== 16'(m_cnt[c])) begin n_fail++; $display("FAIL stats_rand ch=%0d got %0d want %0d", c, grant_cnt[c*16 +: 16], m_cnt[c]); end
    end
`endif
  endtask

`ifdef MUX_RR_STATS_EN
  task automatic test_stats_saturate();
    apply_reset();
    ident_data();
    mode = 1'b0;
    sel = 3'd0;
    in_valid = 8'b0000_0001;
    out_ready = 1'b1;
    repeat (65540) begin
      settle();
      tick();
    end
    n_chk++;
    if (grant_cnt[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat got %h want ffff", grant_cnt[15:0]); end
    n_chk++;
    if (grant_cnt[N*16-1:16] !== '0) begin n_fail++; $display("FAIL stats_others got %h want 0", grant_cnt[N*16-1:16]); end
  endtask
`endif

  initial begin
    test_reset();
    test_manual_sweep();
    test_rr_fair();
    test_sparse_rr();
    test_back_pressure();
    test_no_grant();
    test_reset_mid();
    test_random();
`ifdef MUX_RR_STATS_EN
    test_stats_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
